// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding and default constants.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NopInstrDefault = 16'h0800;
  localparam logic [7:0]  WaitMaxDefault  = 8'd255;
  localparam logic [15:0] PcStep          = 16'd2;

endpackage

// File: rtl/fetch_ctrl_cla16b.sv
// 16-bit carry-lookahead adder (4-bit groups, lookahead across groups), no carry-out.
module fetch_ctrl_cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  // Top bit's generate only feeds a carry-out, which nobody needs.
  logic [14:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  gg;
  logic [2:0]  pg;
  logic [3:0]  bc;

  assign g = a[14:0] & b[14:0];
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    bc = '0;
    c  = '0;
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    bc[0] = cin;
    for (int k = 0; k < 3; k++) begin
      bc[k+1] = gg[k] | (pg[k] & bc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = bc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues reads for pc_in, waits on a variable-latency memory,
// registers the fetched word and PC+2 for decode, and handles flush and timeout.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] NopInstr = NopInstrDefault,
  parameter logic [7:0]  WaitMax  = WaitMaxDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  input  logic        flush,
  input  logic        id_stall,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  output logic        pc_stall,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  req_pc_q, pend_q;
  logic [7:0]   wait_cnt_q;
  logic [15:0]  if_instr_q, if_pc2_q;
  logic         if_valid_q, err_q;

  logic         blocked, req_rd, taken, timeout;
  logic         accept, err_d;
  logic [15:0]  acc_data, acc_pc, acc_pc2;

  assign blocked = if_valid_q & id_stall;
  assign req_rd  = ~blocked & ~flush & ~pc_in[0];
  assign taken   = req_rd & ~imem_stall;
  assign timeout = (wait_cnt_q == WaitMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StReq;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: if (taken & ~imem_done) state_d = StWait;
      StWait: begin
        if (flush)          state_d = imem_done ? StReq : StDrain;
        // A decode stall while the read is outstanding parks the word in pend.
        else if (imem_done) state_d = id_stall ? StHold : StReq;
        else if (timeout)   state_d = StReq;
      end
      StHold:  if (flush | ~id_stall) state_d = StReq;
      StDrain: if (imem_done | timeout) state_d = StReq;
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = req_pc_q;
    accept    = 1'b0;
    acc_data  = imem_data;
    acc_pc    = req_pc_q;
    err_d     = 1'b0;
    unique case (state_q)
      StReq: begin
        imem_rd   = req_rd & ~rst;
        imem_addr = pc_in;
        acc_pc    = pc_in;
        accept    = taken & imem_done;
        err_d     = pc_in[0] & ~blocked & ~flush;
      end
      StWait: begin
        accept = ~flush & imem_done & ~id_stall;
        err_d  = ~flush & ~imem_done & timeout;
      end
      StHold: begin
        acc_data = pend_q;
        accept   = ~flush & ~id_stall;
      end
      StDrain: err_d = ~flush & ~imem_done & timeout;
      default: ;
    endcase
    pc_stall = rst | flush | ~accept;
  end

  fetch_ctrl_cla16b u_pc_add (
    .a   (acc_pc),
    .b   (PcStep),
    .cin (1'b0),
    .sum (acc_pc2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q   <= '0;
      pend_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == StReq && taken) req_pc_q <= pc_in;
      if (state_q == StWait && ~flush && imem_done && id_stall) pend_q <= imem_data;
      if (state_q == StReq) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait || state_q == StDrain) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_instr_q <= NopInstr;
      if_pc2_q   <= '0;
      if_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (flush) begin
        if_instr_q <= NopInstr;
        if_valid_q <= 1'b0;
      end else if (accept) begin
        if_instr_q <= acc_data;
        if_pc2_q   <= acc_pc2;
        if_valid_q <= 1'b1;
      end else if (err_d) begin
        if_instr_q <= NopInstr;
        if_valid_q <= 1'b1;
      end else if (!blocked) begin
        if_instr_q <= NopInstr;
        if_valid_q <= 1'b0;
      end
    end
  end

  assign if_instr = if_instr_q;
  assign if_pc2   = if_pc2_q;
  assign if_valid = if_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed corner cases plus randomized traffic
// checked against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [15:0] Nop = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in;
  logic        flush, id_stall, imem_stall, imem_done;
  logic [15:0] imem_data;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        pc_stall;
  logic [15:0] if_instr, if_pc2;
  logic        if_valid, err;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .flush      (flush),
    .id_stall   (id_stall),
    .imem_stall (imem_stall),
    .imem_done  (imem_done),
    .imem_data  (imem_data),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .pc_stall   (pc_stall),
    .if_instr   (if_instr),
    .if_pc2     (if_pc2),
    .if_valid   (if_valid),
    .err        (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding read, an optional parked word, a drain flag.
  bit          m_busy, m_drain, m_parked;
  logic [15:0] m_req_pc, m_park;
  int          m_waited;
  logic [15:0] m_instr, m_pc2;
  bit          m_valid, m_err;

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_parked = 0;
    m_req_pc = '0; m_park = '0; m_waited = 0;
    m_instr = Nop; m_pc2 = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic cycle(input logic [15:0] pc, input bit fl, input bit ids, input bit ist,
                       input bit idn, input logic [15:0] dat, output bit stall_exp);
    bit          blocked, idle, e_rd, acc, e_err, chk_addr;
    logic [15:0] e_addr, a_data, a_pc;
    pc_in = pc; flush = fl; id_stall = ids; imem_stall = ist; imem_done = idn; imem_data = dat;
    #1;
    blocked = m_valid && ids;
    idle = !(m_busy || m_drain || m_parked);
    e_rd = 0; acc = 0; e_err = 0;
    e_addr = m_req_pc; a_data = dat; a_pc = m_req_pc;
    chk_addr = idle || m_busy;
    if (idle) begin
      e_addr = pc; a_pc = pc;
      e_rd = !blocked && !fl && !pc[0];
      e_err = pc[0] && !blocked && !fl;
      if (e_rd && !ist) begin
        m_req_pc = pc;
        if (idn) acc = 1;
        else begin m_busy = 1; m_waited = 0; end
      end
    end else if (m_parked) begin
      a_data = m_park;
      if (fl) m_parked = 0;
      else if (!ids) begin acc = 1; m_parked = 0; end
    end else if (m_busy) begin
      if (fl) begin
        m_busy = 0;
        if (!idn) begin m_drain = 1; m_waited++; end
      end else if (idn) begin
        m_busy = 0;
        if (ids) begin m_parked = 1; m_park = dat; end
        else acc = 1;
      end else if (m_waited == 255) begin
        e_err = 1; m_busy = 0;
      end else m_waited++;
    end else begin
      if (idn) m_drain = 0;
      else if (m_waited == 255) begin m_drain = 0; e_err = !fl; end
      else m_waited++;
    end
    stall_exp = fl || !acc;
    check("imem_rd", imem_rd, e_rd);
    if (chk_addr) check("imem_addr", imem_addr, e_addr);
    check("pc_stall", pc_stall, stall_exp);
    if (fl) begin m_instr = Nop; m_valid = 0; end
    else if (acc) begin m_instr = a_data; m_pc2 = a_pc + 16'd2; m_valid = 1; end
    else if (e_err) begin m_instr = Nop; m_valid = 1; end
    else if (!blocked) begin m_instr = Nop; m_valid = 0; end
    m_err = e_err;
    @(posedge clk);
    #1;
    check("if_instr", if_instr, m_instr);
    check("if_pc2", if_pc2, m_pc2);
    check("if_valid", if_valid, m_valid);
    check("err", err, m_err);
  endtask

  task automatic do_reset();
    rst = 1; pc_in = '0; flush = 0; id_stall = 0; imem_stall = 0; imem_done = 0; imem_data = '0;
    #1;
    check("rst_imem_rd", imem_rd, 1'b0);
    check("rst_pc_stall", pc_stall, 1'b1);
    @(posedge clk); #1;
    check("rst_instr", if_instr, Nop);
    check("rst_valid", if_valid, 1'b0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit          st;
    logic [15:0] pc;
    bit          fl, ids, ist, idn;
    model_reset();
    do_reset();

    // Back-to-back hits from PC 0.
    cycle(16'h0000, 0, 0, 0, 1, 16'h1111, st); check("hit0_pc2", if_pc2, 16'h0002);
    check("hit0_stall", st, 1'b0);
    cycle(16'h0002, 0, 0, 0, 1, 16'h2222, st); check("hit1_pc2", if_pc2, 16'h0004);
    cycle(16'h0004, 0, 0, 0, 1, 16'h3333, st); check("hit2_pc2", if_pc2, 16'h0006);
    check("hit2_instr", if_instr, 16'h3333);

    // PC wrap on a hit at the top of memory.
    cycle(16'hFFFE, 0, 0, 0, 1, 16'hABCD, st); check("wrap_pc2", if_pc2, 16'h0000);

    // Misaligned PC.
    cycle(16'h0003, 0, 0, 0, 1, 16'h5555, st);
    check("mis_err", err, 1'b1); check("mis_instr", if_instr, Nop); check("mis_valid", if_valid, 1'b1);
    cycle(16'h0004, 0, 0, 0, 1, 16'h4444, st); check("mis_err_clr", err, 1'b0);

    // Miss, decode stalls while waiting, word parks, then releases.
    cycle(16'h0010, 0, 0, 0, 0, 16'h0, st);
    cycle(16'h0010, 0, 1, 0, 0, 16'h0, st);
    cycle(16'h0010, 0, 1, 0, 1, 16'hBEEF, st); check("hold_valid", if_valid, 1'b0);
    cycle(16'h0010, 0, 0, 0, 0, 16'h0, st); check("hold_rel_stall", st, 1'b0);
    check("hold_rel_instr", if_instr, 16'hBEEF); check("hold_rel_pc2", if_pc2, 16'h0012);

    // Timeout with no done.
    cycle(16'h0020, 0, 0, 0, 0, 16'h0, st);
    for (int i = 0; i < 256; i++) cycle(16'h0020, 0, 0, 0, 0, 16'h0, st);
    check("tmo_err", err, 1'b1); check("tmo_valid", if_valid, 1'b1);
    cycle(16'h0022, 0, 0, 0, 1, 16'h7777, st); check("tmo_back_req", if_instr, 16'h7777);

    // Asynchronous reset in the middle of a wait.
    cycle(16'h0040, 0, 0, 0, 1, 16'h9999, st);
    cycle(16'h0042, 0, 0, 0, 0, 16'h0, st);
    cycle(16'h0042, 0, 0, 0, 0, 16'h0, st);
    #2 rst = 1;
    #1;
    check("arst_instr", if_instr, Nop); check("arst_pc2", if_pc2, 16'h0000);
    check("arst_valid", if_valid, 1'b0); check("arst_err", err, 1'b0);
    check("arst_rd", imem_rd, 1'b0); check("arst_stall", pc_stall, 1'b1);
    do_reset();

    // Randomized traffic with a simple PC register driven by the model's pc_stall.
    pc = 16'h0100;
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(0, 99) < (pc[0] ? 50 : 6));
      ids = ($urandom_range(0, 99) < 30);
      ist = ($urandom_range(0, 99) < 20);
      idn = ($urandom_range(0, 99) < 40);
      cycle(pc, fl, ids, ist, idn, 16'($urandom), st);
      if (fl) begin
        pc = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 19) == 0) pc[0] = 1'b1;
      end else if (!st) begin
        pc = pc + 16'd2;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
